param_adder_acc: RTL and testbench
==================================

PARAM_ADDER_ACC -- requirements
Module: param_adder_acc

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits (legal 2..16).
REQ-002 Parameter ACC_WIDTH, default 8, result/accumulator width (legal ≥ 2*WIDTH, ≤ 32).
REQ-003 Parameter SATURATE, default 0, 0 = wrap on overflow, 1 = clamp to limit.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 op_a  input  WIDTH  operand A, unsigned.
REQ-009 op_b  input  WIDTH  operand B, unsigned.
REQ-010 mode  input  2  00 ADD, 01 SUB, 10 ACC, 11 MAC; sampled with beat.
REQ-011 acc_clear  input  1  synchronous accumulator clear.
REQ-012 out_valid  output  1  result register holds unread result.
REQ-013 out_ready  input  1  consumer takes result this cycle.
REQ-014 result  output  ACC_WIDTH  registered result.
REQ-015 ovf  output  1  overflow/borrow flag for the result in result.

Function
REQ-016 Beat accepted when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
REQ-017 Output buffer FSM SHALL have states EMPTY and FULL; EMPTY→FULL on accept; FULL→EMPTY on out_ready without accept; FULL stays FULL on out_ready with accept (new result loaded).
REQ-018 Latency SHALL be exactly 1 cycle: result/ovf/out_valid valid the cycle after accept.
REQ-019 While FULL and out_ready low, result and ovf SHALL hold stable.
REQ-020 ADD: result = zero-extended op_a + op_b; ovf = 0.
REQ-021 SUB: result = (op_a - op_b) mod 2^ACC_WIDTH; ovf = 1 when op_b > op_a; SATURATE=1 clamps result to 0 on borrow.
REQ-022 ACC: acc_next = acc + op_a + op_b; MAC: acc_next = acc + op_a*op_b; result = acc_next; accumulator not touched by ADD/SUB.
REQ-023 ACC/MAC overflow: true sum ≥ 2^ACC_WIDTH sets ovf = 1; SATURATE=0 stores wrapped value, SATURATE=1 stores and outputs 2^ACC_WIDTH-1.
REQ-024 acc_clear without accept: acc ← 0 next edge, no output produced.
REQ-025 acc_clear with accepted ACC/MAC beat: clear applies first (acc_next = 0 + term).
REQ-026 acc_clear with accepted ADD/SUB beat: both take effect independently.
REQ-027 Accumulator SHALL update only on accept, never under backpressure.

Reset
REQ-028 On reset: out_valid = 0, result = 0, ovf = 0, accumulator = 0, FSM = EMPTY.
REQ-029 Reset mid-operation SHALL discard any buffered result; in_ready = 1 the first cycle after deassertion.

Structure
REQ-030 Shared package SHALL hold the mode enum (MODE_ADD, MODE_SUB, MODE_ACC, MODE_MAC) and the FSM state enum.
REQ-031 Combinational arithmetic (add/sub/mul, overflow detect, saturation) SHALL be one sub-module, param_adder_acc_dp; the top holds accumulator, output register and FSM.

Verification (WIDTH=4, ACC_WIDTH=8)
REQ-032 ADD 15+15, out_ready=1 -> next cycle result=0x1E, ovf=0, out_valid=1.
REQ-033 SUB 3-5, SATURATE=0 -> result=0xFE, ovf=1; SATURATE=1 -> result=0x00, ovf=1.
REQ-034 Nine ACC beats of 15+15 -> 8th result=240 ovf=0; 9th result=14 ovf=1 (SATURATE=0) or 255 ovf=1 (SATURATE=1).
REQ-035 MAC 15*15 then acc_clear+MAC 2*3 in same beat -> results 225 then 6.
REQ-036 Hold out_ready=0 three cycles after one beat -> in_ready=0, result stable, accumulator unchanged; release -> accept resumes same cycle.
REQ-037 Assert reset while FULL with acc=100 -> out_valid=0, result=0, acc=0; next ACC 1+1 -> result=2.

Source files
------------

// File: rtl/param_adder_acc_pkg.sv
// Shared types for the parameterised adder/accumulator: operation modes and output-buffer states.
package param_adder_acc_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_MAC = 2'b11
    } mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // True for the modes that read and write the accumulator.
    function automatic logic is_acc_mode(input mode_e m);
        return (m == MODE_ACC) || (m == MODE_MAC);
    endfunction

endpackage

// File: rtl/param_adder_acc_if.sv
// Operand/result handshake bundle between a producer/consumer (master) and the adder (slave).
interface param_adder_acc_if #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ACC_WIDTH = 8
);
    import param_adder_acc_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    mode_e                mode;
    logic                 acc_clear;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] result;
    logic                 ovf;

    modport master (
        output in_valid, op_a, op_b, mode, acc_clear, out_ready,
        input  in_ready, out_valid, result, ovf
    );

    modport slave (
        input  in_valid, op_a, op_b, mode, acc_clear, out_ready,
        output in_ready, out_valid, result, ovf
    );

endinterface

// File: rtl/param_adder_acc_dp.sv
// Combinational datapath: add/sub/accumulate/multiply-accumulate with overflow detect and optional clamp.
module param_adder_acc_dp
    import param_adder_acc_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ACC_WIDTH = 8,
    parameter int unsigned SATURATE  = 0
) (
    input  logic [WIDTH-1:0]     op_a_i,
    input  logic [WIDTH-1:0]     op_b_i,
    input  mode_e                mode_i,
    input  logic [ACC_WIDTH-1:0] acc_i,
    output logic [ACC_WIDTH-1:0] res_o,
    output logic                 ovf_o
);

    // One guard bit above the result catches carry-out; ACC_WIDTH >= 2*WIDTH keeps every term inside it.
    localparam int unsigned EXT_W = ACC_WIDTH + 1;

    logic [EXT_W-1:0] a_ext;
    logic [EXT_W-1:0] b_ext;
    logic [EXT_W-1:0] acc_ext;
    logic [EXT_W-1:0] calc_ext;

    // Select the operation, flag overflow/borrow, clamp when saturating.
    always_comb begin
        a_ext    = EXT_W'(op_a_i);
        b_ext    = EXT_W'(op_b_i);
        acc_ext  = EXT_W'(acc_i);
        calc_ext = '0;
        res_o    = '0;
        ovf_o    = 1'b0;
        case (mode_i)
            MODE_ADD: begin
                calc_ext = a_ext + b_ext;
                res_o    = calc_ext[ACC_WIDTH-1:0];
            end
            MODE_SUB: begin
                calc_ext = a_ext - b_ext;
                ovf_o    = (op_b_i > op_a_i);
                res_o    = (ovf_o && (SATURATE != 0)) ? '0 : calc_ext[ACC_WIDTH-1:0];
            end
            MODE_ACC: begin
                calc_ext = acc_ext + a_ext + b_ext;
                ovf_o    = calc_ext[ACC_WIDTH];
                res_o    = (ovf_o && (SATURATE != 0)) ? '1 : calc_ext[ACC_WIDTH-1:0];
            end
            MODE_MAC: begin
                calc_ext = acc_ext + (a_ext * b_ext);
                ovf_o    = calc_ext[ACC_WIDTH];
                res_o    = (ovf_o && (SATURATE != 0)) ? '1 : calc_ext[ACC_WIDTH-1:0];
            end
            default: begin
                res_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/param_adder_acc.sv
// Adder/accumulator top: accumulator, one-entry result buffer and its EMPTY/FULL control.
module param_adder_acc
    import param_adder_acc_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ACC_WIDTH = 8,
    parameter int unsigned SATURATE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    param_adder_acc_if.slave bus
);

    state_e               state_q;
    state_e               state_d;
    logic                 accept_c;
    logic                 load_c;
    logic                 acc_we_c;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [ACC_WIDTH-1:0] acc_base_c;
    logic [ACC_WIDTH-1:0] dp_res_c;
    logic                 dp_ovf_c;
    logic [ACC_WIDTH-1:0] result_q;
    logic                 ovf_q;

    // Ready whenever the buffer is free or is being drained this cycle.
    assign bus.in_ready  = (state_q == ST_EMPTY) || bus.out_ready;
    assign accept_c      = bus.in_valid && bus.in_ready;
    // A clear coinciding with an accumulate beat is applied before the add.
    assign acc_base_c    = bus.acc_clear ? '0 : acc_q;

    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;

    param_adder_acc_dp #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .SATURATE  (SATURATE)
    ) u_dp (
        .op_a_i (bus.op_a),
        .op_b_i (bus.op_b),
        .mode_i (bus.mode),
        .acc_i  (acc_base_c),
        .res_o  (dp_res_c),
        .ovf_o  (dp_ovf_c)
    );

    // Buffer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Buffer next-state: fill on accept, empty on drain without a refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept_c) state_d = ST_FULL;
            ST_FULL:  if (!accept_c && bus.out_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Load enables for the result buffer and accumulator.
    always_comb begin
        load_c   = accept_c;
        acc_we_c = bus.acc_clear || (accept_c && is_acc_mode(bus.mode));
        acc_d    = (accept_c && is_acc_mode(bus.mode)) ? dp_res_c : '0;
    end

    // Accumulator: written only by a clear or an accepted accumulate beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (acc_we_c) begin
            acc_q <= acc_d;
        end
    end

    // Result buffer: captured on accept, held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else if (load_c) begin
            result_q <= dp_res_c;
            ovf_q    <= dp_ovf_c;
        end
    end

endmodule

// File: tb/tb_param_adder_acc.sv
// Directed bench: a wrapping and a saturating instance driven with identical beats.
module tb_param_adder_acc;
    import param_adder_acc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    param_adder_acc_if #(.WIDTH(4), .ACC_WIDTH(8)) bus_w ();
    param_adder_acc_if #(.WIDTH(4), .ACC_WIDTH(8)) bus_s ();

    param_adder_acc #(.WIDTH(4), .ACC_WIDTH(8), .SATURATE(0)) u_dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w.slave)
    );

    param_adder_acc #(.WIDTH(4), .ACC_WIDTH(8), .SATURATE(1)) u_dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input mode_e m, input logic clr, input logic ordy);
        bus_w.in_valid = v;  bus_w.op_a = a; bus_w.op_b = b;
        bus_w.mode = m;      bus_w.acc_clear = clr; bus_w.out_ready = ordy;
        bus_s.in_valid = v;  bus_s.op_a = a; bus_s.op_b = b;
        bus_s.mode = m;      bus_s.acc_clear = clr; bus_s.out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v,
                              input logic [7:0] rw, input logic ow,
                              input logic [7:0] rs, input logic os);
        check({tag, "_w_valid"}, 32'(bus_w.out_valid), 32'(v));
        check({tag, "_s_valid"}, 32'(bus_s.out_valid), 32'(v));
        check({tag, "_w_result"}, 32'(bus_w.result), 32'(rw));
        check({tag, "_w_ovf"}, 32'(bus_w.ovf), 32'(ow));
        check({tag, "_s_result"}, 32'(bus_s.result), 32'(rs));
        check({tag, "_s_ovf"}, 32'(bus_s.ovf), 32'(os));
    endtask

    task automatic expect_ready(input string tag, input logic r);
        check({tag, "_w_ready"}, 32'(bus_w.in_ready), 32'(r));
        check({tag, "_s_ready"}, 32'(bus_s.in_ready), 32'(r));
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 4'd0, 4'd0, MODE_ADD, 1'b0, 1'b0);
        repeat (2) step();
        expect_out("reset", 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        expect_ready("reset", 1'b1);
        reset = 1'b0;

        // ADD 15+15
        drive(1'b1, 4'd15, 4'd15, MODE_ADD, 1'b0, 1'b1);
        step();
        expect_out("add_15_15", 1'b1, 8'h1E, 1'b0, 8'h1E, 1'b0);

        // SUB 3-5 borrows
        drive(1'b1, 4'd3, 4'd5, MODE_SUB, 1'b0, 1'b1);
        step();
        expect_out("sub_3_5", 1'b1, 8'hFE, 1'b1, 8'h00, 1'b1);

        // SUB 9-4 without borrow
        drive(1'b1, 4'd9, 4'd4, MODE_SUB, 1'b0, 1'b1);
        step();
        expect_out("sub_9_4", 1'b1, 8'd5, 1'b0, 8'd5, 1'b0);

        // Nine ACC beats of 15+15; accumulator untouched by the ADD/SUB above
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 4'd15, 4'd15, MODE_ACC, 1'b0, 1'b1);
            step();
            if (i < 8)
                expect_out($sformatf("acc_beat%0d", i), 1'b1, 8'(30 * (i + 1)), 1'b0,
                           8'(30 * (i + 1)), 1'b0);
            else
                expect_out("acc_beat8", 1'b1, 8'd14, 1'b1, 8'd255, 1'b1);
        end

        // Clear alone: no output produced
        drive(1'b0, 4'd0, 4'd0, MODE_ACC, 1'b1, 1'b1);
        step();
        check("clear_only_w_valid", 32'(bus_w.out_valid), 32'd0);
        check("clear_only_s_valid", 32'(bus_s.out_valid), 32'd0);

        // MAC 15*15 from a cleared accumulator, then clear+MAC 2*3
        drive(1'b1, 4'd15, 4'd15, MODE_MAC, 1'b0, 1'b1);
        step();
        expect_out("mac_15_15", 1'b1, 8'd225, 1'b0, 8'd225, 1'b0);
        drive(1'b1, 4'd2, 4'd3, MODE_MAC, 1'b1, 1'b1);
        step();
        expect_out("clr_mac_2_3", 1'b1, 8'd6, 1'b0, 8'd6, 1'b0);

        // Backpressure: three cycles stalled with an ACC beat pending
        drive(1'b1, 4'd1, 4'd1, MODE_ACC, 1'b0, 1'b0);
        #1;
        expect_ready("stall_enter", 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("stall%0d", i), 1'b1, 8'd6, 1'b0, 8'd6, 1'b0);
            expect_ready($sformatf("stall%0d", i), 1'b0);
        end
        drive(1'b1, 4'd1, 4'd1, MODE_ACC, 1'b0, 1'b1);
        #1;
        expect_ready("release", 1'b1);
        step();
        expect_out("after_release", 1'b1, 8'd8, 1'b0, 8'd8, 1'b0);

        // Load acc=100, then reset while FULL
        drive(1'b1, 4'd10, 4'd10, MODE_MAC, 1'b1, 1'b1);
        step();
        expect_out("mac_10_10", 1'b1, 8'd100, 1'b0, 8'd100, 1'b0);
        drive(1'b0, 4'd0, 4'd0, MODE_ADD, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        expect_out("mid_reset", 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        step();
        reset = 1'b0;
        #1;
        expect_ready("post_reset", 1'b1);
        drive(1'b1, 4'd1, 4'd1, MODE_ACC, 1'b0, 1'b1);
        step();
        expect_out("acc_after_reset", 1'b1, 8'd2, 1'b0, 8'd2, 1'b0);

        // Drain
        drive(1'b0, 4'd0, 4'd0, MODE_ADD, 1'b0, 1'b1);
        step();
        check("drain_w_valid", 32'(bus_w.out_valid), 32'd0);
        check("drain_s_valid", 32'(bus_s.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
